// File: rtl/chan_mux_pkg.sv
// Shared types and constants for the round-robin / manual channel multiplexer.
package chan_mux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int DEF_NCH = 4;
  localparam int DEF_W   = 8;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/chan_mux_rr_arbiter.sv
// Combinational rotating-priority search: first requester at or above ptr, wrapping at NCH-1.
module rr_arbiter #(
  parameter  int NCH = 4,
  localparam int SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic [SW-1:0]  gnt_idx,
  output logic           gnt_vld
);

  logic [SW-1:0] cand;

  // Walk from the farthest offset back to ptr so the closest requester wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = SW'((int'(ptr) + i) % NCH);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel to 1 multiplexer with a single output register; manual or round-robin grant.
// Define CHAN_MUX_PKT_LOCK_EN to add in_last/out_last and hold the round-robin grant for a whole packet.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter  int NCH = DEF_NCH,
  parameter  int W   = DEF_W,
  localparam int SW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
`ifdef CHAN_MUX_PKT_LOCK_EN
  input  logic [NCH-1:0]   in_last,
`endif
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
`ifdef CHAN_MUX_PKT_LOCK_EN
  output logic             out_last,
`endif
  input  logic             out_ready,
  output logic [SW-1:0]    cur_ch
);

  state_t        state, state_nxt;
  logic [SW-1:0] ptr, ptr_nxt;
  logic [SW-1:0] arb_idx, gnt_idx;
  logic          arb_vld, gnt_vld;
  logic          load_ok, in_xfer, out_xfer;

`ifdef CHAN_MUX_PKT_LOCK_EN
  logic          lock_act;
  logic [SW-1:0] lock_ch;
`endif

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Manual grant ignores in_valid; an out-of-range sel grants nothing.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    if (mode == MODE_MANUAL) begin
      gnt_idx = sel;
      gnt_vld = (int'(sel) < NCH);
    end
`ifdef CHAN_MUX_PKT_LOCK_EN
    else if (lock_act) begin
      gnt_idx = lock_ch;
      gnt_vld = 1'b1;
    end
`endif
    else begin
      gnt_idx = arb_idx;
      gnt_vld = arb_vld;
    end
  end

  assign load_ok  = (state == EMPTY) || out_ready;
  assign in_xfer  = |(in_ready & in_valid);
  assign out_xfer = out_valid && out_ready;
  assign ptr_nxt  = SW'((int'(gnt_idx) + 1) % NCH);

  always_comb begin
    in_ready = '0;
    if (rst_n && load_ok && gnt_vld) in_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (in_xfer) state_nxt = FULL;
      FULL:    if (out_xfer && !in_xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      cur_ch   <= '0;
`ifdef CHAN_MUX_PKT_LOCK_EN
      out_last <= 1'b0;
`endif
    end else if (in_xfer) begin
      out_data <= in_data[int'(gnt_idx)*W +: W];
      cur_ch   <= gnt_idx;
`ifdef CHAN_MUX_PKT_LOCK_EN
      out_last <= in_last[gnt_idx];
`endif
    end
  end

  // Only round-robin transfers move the pointer; a packet in flight defers it to its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
`ifdef CHAN_MUX_PKT_LOCK_EN
      lock_act <= 1'b0;
      lock_ch  <= '0;
`endif
    end else if (in_xfer && mode == MODE_RR) begin
`ifdef CHAN_MUX_PKT_LOCK_EN
      if (!in_last[gnt_idx]) begin
        lock_act <= 1'b1;
        lock_ch  <= gnt_idx;
      end else begin
        lock_act <= 1'b0;
        ptr      <= ptr_nxt;
      end
`else
      ptr <= ptr_nxt;
`endif
    end
  end

endmodule
